// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block/byte geometry, the serializer FSM
// state type and a helper that picks byte k (MSB first) out of a block.
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_BYTES_PER_BLOCK = 16;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [3:0]             aes_byte_idx_t;

  localparam aes_byte_idx_t AES_LAST_IDX = 4'd15;

  typedef enum logic {
    SER_IDLE,
    SER_STREAM
  } ser_state_e;

  // Byte k of a block, most significant byte first: block[127-8k -: 8].
  function automatic logic [7:0] aes_get_byte(aes_block_t block, aes_byte_idx_t idx);
    return block[AES_BLOCK_W-1-8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/aes_cipher_serializer_if.sv
// Byte-stream valid/ready interface between the cipher serializer (master)
// and the serial-out consumer (slave).
//   ser_valid : byte available on ser_data
//   ser_ready : consumer accepts the byte
//   ser_data  : current byte
//   ser_last  : high with byte 15 of a block
//   ser_par   : even parity of ser_data (only with AES_SER_PARITY_EN)
interface aes_cipher_serializer_if;

  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] ser_data;
  logic       ser_last;
`ifdef AES_SER_PARITY_EN
  logic       ser_par;

  modport master (output ser_valid, ser_data, ser_last, ser_par, input ser_ready);
  modport slave  (input ser_valid, ser_data, ser_last, ser_par, output ser_ready);
`else
  modport master (output ser_valid, ser_data, ser_last, input ser_ready);
  modport slave  (input ser_valid, ser_data, ser_last, output ser_ready);
`endif

endinterface

// File: rtl/aes_block_fifo.sv
// DEPTH-entry FIFO of whole AES blocks.
//   clk, rstn  : clock, asynchronous active-low reset
//   push/push_data : write a block at the tail (ignored when full unless pop)
//   pop        : discard the head block
//   head       : block at the head (meaningful when !empty)
//   full/empty/count : occupancy
// Push and pop in the same cycle while full is legal: the freed slot is
// reused and the count is unchanged.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  aes_block_t               push_data,
  input  logic                     pop,
  output aes_block_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  aes_block_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, so clearing 128-bit words would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_cipher_serializer.sv
// Captures each finished AES block on the rising edge of done, buffers
// whole blocks, and streams them out MSB byte first over a valid/ready
// byte interface.
//   clk, rstn    : clock, asynchronous active-low reset
//   done         : AES completion level; a rising edge captures cipher_text
//   cipher_text  : block to capture
//   ser          : byte stream (master modport)
//   fill_level   : blocks held, including the one streaming
//   busy         : fill_level != 0
//   overflow     : sticky, a block was dropped because the buffer was full
// Optional feature macro: AES_SER_PARITY_EN adds ser_par = ^ser_data.
module aes_cipher_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    done,
  input  aes_block_t              cipher_text,
  aes_cipher_serializer_if.master ser,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    busy,
  output logic                    overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  ser_state_e    state, state_next;
  aes_byte_idx_t byte_idx, byte_idx_next;
  logic          done_q;
  logic          capture;
  logic          xfer;
  logic          pop;
  logic          push_ok;
  logic          fifo_full;
  logic          fifo_empty;
  aes_block_t    head;
  logic          valid_int;
  logic [7:0]    byte_int;

  assign capture = done & ~done_q;
  assign xfer    = valid_int & ser.ser_ready;
  assign pop     = xfer & (byte_idx == AES_LAST_IDX);
  // A capture into a full buffer survives only if the head retires now.
  assign push_ok = capture & (~fifo_full | pop);

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (capture),
    .push_data (cipher_text),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q   <= 1'b0;
      overflow <= 1'b0;
      state    <= SER_IDLE;
      byte_idx <= '0;
    end else begin
      done_q   <= done;
      if (capture & ~push_ok) overflow <= 1'b1;
      state    <= state_next;
      byte_idx <= byte_idx_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    case (state)
      SER_IDLE: begin
        if (push_ok) state_next = SER_STREAM;
      end
      SER_STREAM: begin
        if (xfer) begin
          if (byte_idx == AES_LAST_IDX) begin
            byte_idx_next = '0;
            // Last block retiring with nothing arriving behind it.
            if (fill_level == CW'(1) && !push_ok) state_next = SER_IDLE;
          end else begin
            byte_idx_next = byte_idx + 1'b1;
          end
        end
      end
      default: begin
        state_next    = SER_IDLE;
        byte_idx_next = '0;
      end
    endcase
  end

  // Outputs come straight from state and FIFO storage, so they hold during
  // a stall and have no combinational dependence on ser_ready.
  assign valid_int     = (state == SER_STREAM);
  assign byte_int      = valid_int ? aes_get_byte(head, byte_idx) : 8'h00;
  assign ser.ser_valid = valid_int;
  assign ser.ser_data  = byte_int;
  assign ser.ser_last  = valid_int & (byte_idx == AES_LAST_IDX);
  assign busy          = ~fifo_empty;

`ifdef AES_SER_PARITY_EN
  assign ser.ser_par = ^byte_int;
`endif

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// Scoreboard bench for aes_cipher_serializer: a block-level model predicts
// captures, drops and byte order; a monitor pops expected bytes on every
// transfer.
module tb_aes_cipher_serializer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [127:0] KAT = 128'h3925841D02DC09FBDC118597196A0B32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          done = 1'b0;
  logic [127:0]  cipher_text = '0;
  logic [CW-1:0] fill_level;
  logic          busy;
  logic          overflow;

  aes_cipher_serializer_if ser_if ();

  aes_cipher_serializer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .done        (done),
    .cipher_text (cipher_text),
    .ser         (ser_if),
    .fill_level  (fill_level),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int bytes_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  exp_byte_t    exp_q[$];
  logic [127:0] blk_q[$];
  int           m_idx = 0;
  bit           m_ovf = 1'b0;
  bit           m_done_prev = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at the negedge with the inputs the DUT will
  // sample on the coming posedge.
  always @(negedge clk) begin
    if (!rstn) begin
      blk_q.delete();
      exp_q.delete();
      m_idx = 0;
      m_ovf = 1'b0;
      m_done_prev = 1'b0;
      check("rst_valid", ser_if.ser_valid, 0);
      check("rst_data", ser_if.ser_data, 0);
      check("rst_last", ser_if.ser_last, 0);
      check("rst_fill", fill_level, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
    end else begin
      bit xfer, pop, cap;
      int size_before;
      check("fill_level", fill_level, blk_q.size());
      check("busy", busy, blk_q.size() != 0);
      check("overflow", overflow, m_ovf);
      check("ser_valid", ser_if.ser_valid, blk_q.size() != 0);
      size_before = blk_q.size();
      xfer = (size_before != 0) && ser_if.ser_ready;
      pop  = xfer && (m_idx == 15);
      cap  = done && !m_done_prev;
      m_done_prev = done;
      if (xfer) begin
        if (pop) begin
          m_idx = 0;
          void'(blk_q.pop_front());
        end else begin
          m_idx++;
        end
      end
      if (cap) begin
        if (size_before < DEPTH || pop) begin
          blk_q.push_back(cipher_text);
          for (int k = 0; k < 16; k++) begin
            exp_byte_t e;
            e.data = 8'((cipher_text >> (8 * (15 - k))) & 128'hff);
            e.last = (k == 15);
            exp_q.push_back(e);
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: compares each transferred byte and checks stall stability.
  logic [7:0] prev_data;
  logic       prev_last;
  bit         prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", ser_if.ser_data, prev_data);
        check("stall_last", ser_if.ser_last, prev_last);
      end
      if (ser_if.ser_valid && ser_if.ser_ready) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h, expected no byte at %0t", ser_if.ser_data, $time);
        end else begin
          exp_byte_t e;
          e = exp_q.pop_front();
          check("ser_data", ser_if.ser_data, e.data);
          check("ser_last", ser_if.ser_last, e.last);
`ifdef AES_SER_PARITY_EN
          check("ser_par", ser_if.ser_par, $countones(e.data) % 2);
`endif
        end
      end
      prev_stall = ser_if.ser_valid && !ser_if.ser_ready;
      prev_data  = ser_if.ser_data;
      prev_last  = ser_if.ser_last;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  task automatic pulse(logic [127:0] blk);
    cipher_text = blk;
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(1);
  endtask

  task automatic drain(string name);
    int cyc = 0;
    ser_if.ser_ready = 1'b1;
    while ((exp_q.size() != 0 || blk_q.size() != 0) && cyc < 200) begin
      step(1);
      cyc++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int start;
    bit hit;
    logic [127:0] a, b, c;
    ser_if.ser_ready = 1'b0;
    step(3);
    rstn = 1'b1;

    // Single known block, done held high: exactly one block of 16 bytes.
    start = bytes_seen;
    cipher_text = KAT;
    ser_if.ser_ready = 1'b1;
    done = 1'b1;
    step(1);
    cipher_text = ~KAT;
    step(24);
    check("single_bytes", bytes_seen - start, 16);
    done = 1'b0;
    step(2);

    // Backpressure with ready pattern 1,0,0,1.
    start = bytes_seen;
    pulse(KAT);
    for (int i = 0; i < 48; i++) begin
      ser_if.ser_ready = (i % 4 == 0) || (i % 4 == 3);
      step(1);
    end
    drain("bp");
    check("bp_bytes", bytes_seen - start, 16);

    // Overflow: three blocks into a two-deep buffer with the consumer stalled.
    do_reset();
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    ser_if.ser_ready = 1'b0;
    start = bytes_seen;
    pulse(a);
    pulse(b);
    pulse(c);
    check("ovf_fill", fill_level, DEPTH);
    check("ovf_flag", overflow, 1);
    drain("ovf");
    check("ovf_bytes", bytes_seen - start, 32);

    // Full buffer plus capture landing on the head's final-byte transfer.
    do_reset();
    ser_if.ser_ready = 1'b1;
    pulse({$urandom, $urandom, $urandom, $urandom});
    pulse({$urandom, $urandom, $urandom, $urandom});
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (blk_q.size() == DEPTH && m_idx == 15) begin
        hit = 1'b1;
        cipher_text = {$urandom, $urandom, $urandom, $urandom};
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("fullpop_fill", fill_level, DEPTH);
        check("fullpop_ovf", overflow, 0);
      end else begin
        step(1);
      end
    end
    check("fullpop_reached", hit, 1);
    drain("fullpop");

    // Reset after byte 5 of a block: nothing may follow until a new edge.
    do_reset();
    ser_if.ser_ready = 1'b1;
    start = bytes_seen;
    pulse(KAT);
    for (int i = 0; i < 40 && bytes_seen - start < 6; i++) step(1);
    check("mid_bytes_before", bytes_seen - start, 6);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", ser_if.ser_valid, 0);
    check("mid_rst_fill", fill_level, 0);
    step(2);
    rstn = 1'b1;
    start = bytes_seen;
    step(30);
    check("mid_no_remnant", bytes_seen - start, 0);

    // Randomized traffic: random done toggles, blocks and ready.
    for (int i = 0; i < 1500; i++) begin
      ser_if.ser_ready = ($urandom_range(0, 3) != 0);
      cipher_text = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) == 0) done = ~done;
      step(1);
    end
    done = 1'b0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
